// File: rtl/ring_grey_enc.sv
// Decimal digit register with single-bit-change ring/grey encoding for the LED decoder,
// plus a timed decimal-point display window.
module ring_grey_enc #(
    parameter int DP_CYCLES = 4,
    parameter int CW        = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_step,
    input  logic       i_up,
    input  logic       i_load,
    input  logic [3:0] i_digit,
    input  logic       i_dp_req,
    output logic [4:0] o_grey,
    output logic [3:0] o_digit,
    output logic       o_carry,
    output logic       o_dp_busy,
    output logic       o_err
);

    // state | meaning
    // COUNT | o_grey tracks the digit; a DP request opens the window
    // DP    | o_grey shows 10101 until the hold counter reaches zero
    typedef enum logic {
        COUNT = 1'b0,
        DP    = 1'b1
    } state_t;

    localparam logic [CW-1:0] DP_LOAD = CW'(DP_CYCLES - 1);
    localparam logic [4:0]    GREY_DP = 5'b10101;

    function automatic logic [4:0] grey_of(input logic [3:0] d);
        logic [4:0] g;
        case (d)
            4'd0:    g = 5'b10001;
            4'd1:    g = 5'b00001;
            4'd2:    g = 5'b00011;
            4'd3:    g = 5'b00010;
            4'd4:    g = 5'b00110;
            4'd5:    g = 5'b00100;
            4'd6:    g = 5'b01100;
            4'd7:    g = 5'b01000;
            4'd8:    g = 5'b11000;
            4'd9:    g = 5'b10000;
            default: g = 5'b10001;
        endcase
        return g;
    endfunction

    state_t        state_q, state_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic [3:0]    digit_q, digit_nxt;
    logic          carry_nxt, err_nxt, busy_nxt;
    logic [4:0]    grey_nxt;

    // Illegal loads leave the digit untouched, so the register never leaves 0..9.
    always_comb begin
        digit_nxt = digit_q;
        carry_nxt = 1'b0;
        err_nxt   = 1'b0;
        if (i_load) begin
            if (i_digit <= 4'd9) begin
                digit_nxt = i_digit;
            end else begin
                err_nxt = 1'b1;
            end
        end else if (i_step) begin
            if (i_up) begin
                if (digit_q == 4'd9) begin
                    digit_nxt = 4'd0;
                    carry_nxt = 1'b1;
                end else begin
                    digit_nxt = digit_q + 4'd1;
                end
            end else begin
                if (digit_q == 4'd0) begin
                    digit_nxt = 4'd9;
                    carry_nxt = 1'b1;
                end else begin
                    digit_nxt = digit_q - 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        grey_nxt  = grey_of(digit_nxt);
        busy_nxt  = 1'b0;
        case (state_q)
            COUNT: begin
                if (i_dp_req) begin
                    state_nxt = DP;
                    cnt_nxt   = DP_LOAD;
                    grey_nxt  = GREY_DP;
                    busy_nxt  = 1'b1;
                end
            end
            DP: begin
                if (cnt_q == '0) begin
                    state_nxt = COUNT;
                end else begin
                    cnt_nxt  = cnt_q - CW'(1);
                    grey_nxt = GREY_DP;
                    busy_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = COUNT;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= COUNT;
            cnt_q     <= '0;
            digit_q   <= 4'd0;
            o_grey    <= 5'b10001;
            o_carry   <= 1'b0;
            o_err     <= 1'b0;
            o_dp_busy <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            digit_q   <= digit_nxt;
            o_grey    <= grey_nxt;
            o_carry   <= carry_nxt;
            o_err     <= err_nxt;
            o_dp_busy <= busy_nxt;
        end
    end

    assign o_digit = digit_q;

endmodule

// File: tb/tb_ring_grey_enc.sv
// Scoreboard bench for ring_grey_enc: a behavioural model queues expected outputs per cycle.
module tb_ring_grey_enc;

    localparam int DP_CYCLES = 4;

    logic       i_clk = 1'b0;
    logic       i_rst, i_step, i_up, i_load, i_dp_req;
    logic [3:0] i_digit;
    logic [4:0] o_grey;
    logic [3:0] o_digit;
    logic       o_carry, o_dp_busy, o_err;

    ring_grey_enc #(.DP_CYCLES(DP_CYCLES), .CW(3)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_step   (i_step),
        .i_up     (i_up),
        .i_load   (i_load),
        .i_digit  (i_digit),
        .i_dp_req (i_dp_req),
        .o_grey   (o_grey),
        .o_digit  (o_digit),
        .o_carry  (o_carry),
        .o_dp_busy(o_dp_busy),
        .o_err    (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [4:0] grey;
        logic [3:0] digit;
        logic       carry;
        logic       busy;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // model state: digit and number of DP cycles already shown in the current window
    int m_digit = 0;
    int m_shown = 0;

    function automatic logic [4:0] code_of(input int d);
        case (d)
            0: return 5'b10001;
            1: return 5'b00001;
            2: return 5'b00011;
            3: return 5'b00010;
            4: return 5'b00110;
            5: return 5'b00100;
            6: return 5'b01100;
            7: return 5'b01000;
            8: return 5'b11000;
            9: return 5'b10000;
            default: return 5'b11111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input logic rst, input logic step, input logic up, input logic load,
                       input logic [3:0] dig, input logic req);
        exp_t e;
        exp_t g;
        i_rst = rst; i_step = step; i_up = up; i_load = load; i_digit = dig; i_dp_req = req;
        e = '0;
        if (rst) begin
            m_digit = 0;
            m_shown = 0;
            e.grey  = 5'b10001;
        end else begin
            if (load) begin
                if (int'(dig) <= 9) m_digit = int'(dig);
                else e.err = 1'b1;
            end else if (step) begin
                if (up) begin
                    e.carry = (m_digit == 9);
                    m_digit = (m_digit + 1) % 10;
                end else begin
                    e.carry = (m_digit == 0);
                    m_digit = (m_digit + 9) % 10;
                end
            end
            if (m_shown > 0 && m_shown < DP_CYCLES) begin
                m_shown++;
                e.grey = 5'b10101;
                e.busy = 1'b1;
            end else if (m_shown >= DP_CYCLES) begin
                m_shown = 0;
                e.grey  = code_of(m_digit);
            end else if (req) begin
                m_shown = 1;
                e.grey  = 5'b10101;
                e.busy  = 1'b1;
            end else begin
                e.grey = code_of(m_digit);
            end
        end
        e.digit = 4'(m_digit);
        sb.push_back(e);
        @(posedge i_clk);
        #1;
        g = sb.pop_front();
        chk("grey",  {3'b0, o_grey},    {3'b0, g.grey});
        chk("digit", {4'b0, o_digit},   {4'b0, g.digit});
        chk("carry", {7'b0, o_carry},   {7'b0, g.carry});
        chk("busy",  {7'b0, o_dp_busy}, {7'b0, g.busy});
        chk("err",   {7'b0, o_err},     {7'b0, g.err});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 4'd0, 0);
    endtask

    logic [4:0] prev_grey;

    initial begin
        i_rst = 1'b1; i_step = 0; i_up = 0; i_load = 0; i_digit = 0; i_dp_req = 0;
        cyc(1, 0, 0, 0, 4'd0, 0);
        cyc(1, 0, 0, 0, 4'd0, 0);
        chk("reset_grey", {3'b0, o_grey}, 8'h11);

        // count up through the wrap, single-bit changes each step
        prev_grey = o_grey;
        for (int k = 0; k < 12; k++) begin
            cyc(0, 1, 1, 0, 4'd0, 0);
            chk("hamming", 8'($countones(o_grey ^ prev_grey)), 8'd1);
            prev_grey = o_grey;
        end

        // wrap downward
        cyc(0, 0, 0, 1, 4'd0, 0);
        cyc(0, 1, 0, 0, 4'd0, 0);
        chk("down_wrap_grey", {3'b0, o_grey}, 8'h10);
        cyc(0, 1, 0, 0, 4'd0, 0);

        // load beats step; illegal load flags and holds
        cyc(0, 1, 1, 1, 4'd7, 0);
        cyc(0, 0, 0, 1, 4'd12, 0);
        chk("bad_load_grey", {3'b0, o_grey}, 8'h08);
        cyc(0, 0, 0, 1, 4'd15, 0);
        idle(1);

        // DP window with a retrigger attempt on its 2nd cycle
        cyc(0, 0, 0, 1, 4'd3, 0);
        cyc(0, 0, 0, 0, 4'd0, 1);
        cyc(0, 0, 0, 0, 4'd0, 1);
        idle(2);
        chk("dp_last_busy", {7'b0, o_dp_busy}, 8'd1);
        idle(1);
        chk("dp_exit_grey", {3'b0, o_grey}, 8'h02);
        idle(2);

        // wrap during DP, exit shows the updated digit
        cyc(0, 0, 0, 1, 4'd9, 0);
        cyc(0, 0, 0, 0, 4'd0, 1);
        cyc(0, 1, 1, 0, 4'd0, 0);
        idle(3);
        chk("dp_wrap_exit", {3'b0, o_grey}, 8'h11);

        // step together with request: digit moves, display goes DP
        cyc(0, 1, 1, 0, 4'd0, 1);
        cyc(0, 0, 0, 0, 4'd0, 1);
        idle(4);

        // reset in the middle of a DP window
        cyc(0, 0, 0, 1, 4'd5, 0);
        cyc(0, 0, 0, 0, 4'd0, 1);
        cyc(1, 0, 0, 0, 4'd0, 0);
        chk("rst_mid_dp_busy", {7'b0, o_dp_busy}, 8'd0);
        cyc(0, 1, 1, 0, 4'd0, 0);
        chk("post_rst_step", {3'b0, o_grey}, 8'h01);

        // random traffic against the model
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 9) == 0));
        end

        chk("sb_drained", 8'(sb.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
